// File: rtl/fifo_read_packer.sv
// rtl/fifo_read_packer.sv - paced FIFO read controller packing bytes MSB-first into words
// Optional FIFO_PACKER_SLIDE_EN: sliding-window words from the last WORD_BYTES bytes.
module fifo_read_packer #(
    parameter int WORD_BYTES  = 2,
    parameter int PACE_CYCLES = 200000,
    parameter int PACE_W      = 27,
    parameter int USEDW_W     = 11,
    parameter int MIN_LEVEL   = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [USEDW_W-1:0]                usedw,
    output logic                              read_ena,
    input  logic [7:0]                        fifo_rd_dat,
    output logic [8*WORD_BYTES-1:0]           out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(WORD_BYTES+1)-1:0]   fill_count
);

    localparam int FILL_W = $clog2(WORD_BYTES + 1);
    localparam logic [PACE_W-1:0]  PACE_LAST = PACE_W'(PACE_CYCLES - 1);
    localparam logic [USEDW_W-1:0] LEVEL_MIN = USEDW_W'(MIN_LEVEL);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(WORD_BYTES);

    logic [PACE_W-1:0]         pace_cnt;
    logic                      pending;
    logic [8*WORD_BYTES-1:0]   shift_word;
    logic [8*WORD_BYTES+7:0]   shift_ext;
    logic [8*WORD_BYTES-1:0]   shifted;
    logic [FILL_W-1:0]         fill_inc;
    logic                      stalled;
    logic                      issue;
    logic                      complete;

    always_comb begin
        stalled   = out_valid && !out_ready;
        // Gated by reset so no strobe escapes while the registers are being cleared.
        issue     = !reset && (pace_cnt == PACE_LAST) && (usedw >= LEVEL_MIN)
                    && !pending && !stalled;
        // Widening first keeps the shift legal even when WORD_BYTES is 1.
        shift_ext = {shift_word, fifo_rd_dat};
        shifted   = shift_ext[8*WORD_BYTES-1:0];
        fill_inc  = fill_count + FILL_W'(1);
`ifdef FIFO_PACKER_SLIDE_EN
        complete  = pending && ((fill_count == FILL_FULL) || (fill_inc == FILL_FULL));
`else
        complete  = pending && (fill_inc == FILL_FULL);
`endif
    end

    assign read_ena = issue;

    always_ff @(posedge clk) begin
        if (reset) begin
            pace_cnt   <= '0;
            pending    <= 1'b0;
            shift_word <= '0;
            fill_count <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (issue) begin
                pace_cnt <= '0;
            end else if (pace_cnt != PACE_LAST) begin
                pace_cnt <= pace_cnt + PACE_W'(1);
            end

            pending <= issue;

            if (pending) begin
                shift_word <= shifted;
`ifdef FIFO_PACKER_SLIDE_EN
                fill_count <= (fill_count == FILL_FULL) ? FILL_FULL : fill_inc;
`else
                fill_count <= complete ? '0 : fill_inc;
`endif
            end

            // A fresh word takes priority over acceptance of the old one.
            if (complete) begin
                out_data  <= shifted;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_packer.sv
// tb/tb_fifo_read_packer.sv - self-checking bench for fifo_read_packer (PACE_CYCLES=4, WORD_BYTES=2)
module tb_fifo_read_packer;

    logic        clk;
    logic        reset;
    logic [10:0] usedw;
    logic        read_ena;
    logic [7:0]  fifo_rd_dat;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  fill_count;

    int checks = 0;
    int errors = 0;
    int words_seen = 0;

    logic [7:0]  fifo_q[$];
    logic [15:0] sb[$];
    logic [15:0] acc;
    int          acc_n;
    logic [7:0]  rd_byte;

    typedef struct {
        logic [10:0] usedw;
        logic        rdy;
        logic        re;
        logic        ov;
        logic [1:0]  fill;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[18];

    fifo_read_packer #(
        .WORD_BYTES (2),
        .PACE_CYCLES(4),
        .PACE_W     (3),
        .USEDW_W    (11),
        .MIN_LEVEL  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .usedw      (usedw),
        .read_ena   (read_ena),
        .fifo_rd_dat(fifo_rd_dat),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_count (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIFO model: data follows the strobe by one cycle; expected words go to the scoreboard.
    always @(posedge clk) begin
        if (reset) begin
            acc   = '0;
            acc_n = 0;
        end else if (read_ena) begin
            rd_byte = 8'h00;
            if (fifo_q.size() > 0) rd_byte = fifo_q.pop_front();
            fifo_rd_dat <= rd_byte;
            acc = {acc[7:0], rd_byte};
            acc_n++;
`ifdef FIFO_PACKER_SLIDE_EN
            if (acc_n >= 2) sb.push_back(acc);
`else
            if (acc_n == 2) begin
                sb.push_back(acc);
                acc_n = 0;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            words_seen++;
            if (sb.size() == 0) begin
                check("word_unexpected", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                check("word", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        fifo_rd_dat = 8'h00;
        acc         = '0;
        acc_n       = 0;
        reset       = 1'b1;
        usedw       = '0;
        out_ready   = 1'b1;

        // Reset: hold 3 cycles with an empty FIFO, then 20 idle cycles
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data",  32'(out_data), 0);
        check("rst_fill",  32'(fill_count), 0);
        check("rst_read",  32'(read_ena), 0);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            check("idle_read", 32'(read_ena), 0);
            check("idle_valid", 32'(out_valid), 0);
            tick();
        end
        check("idle_data", 32'(out_data), 0);
        check("idle_fill", 32'(fill_count), 0);

`ifdef FIFO_PACKER_SLIDE_EN
        fifo_q = '{8'h01, 8'h02, 8'h03};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        usedw = 11'd5;
        for (int c = 1; c <= 15; c++) begin
            #1;
            check("slide_read",  32'(read_ena), 32'((c % 4) == 0));
            check("slide_valid", 32'(out_valid), 32'((c == 10) || (c == 14)));
            if (c == 10) check("slide_w0", 32'(out_data), 32'h0102);
            if (c == 14) check("slide_w1", 32'(out_data), 32'h0203);
            if (c == 14) check("slide_fill", 32'(fill_count), 2);
            tick();
        end
        usedw = '0;
        repeat (4) tick();
        check("slide_sb_empty", 32'(sb.size()), 0);
        check("slide_words", 32'(words_seen), 2);
`else
        fifo_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h17, 8'h28};
        //            usedw  rdy   re    ov    fill  data
        vecs[0]  = '{11'd5, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000};
        vecs[1]  = '{11'd5, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000};
        vecs[2]  = '{11'd5, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000};
        vecs[3]  = '{11'd5, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000};
        vecs[4]  = '{11'd5, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000};
        vecs[5]  = '{11'd5, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0000};
        vecs[6]  = '{11'd5, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0000};
        vecs[7]  = '{11'd5, 1'b1, 1'b1, 1'b0, 2'd1, 16'h0000};
        vecs[8]  = '{11'd5, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0000};
        vecs[9]  = '{11'd5, 1'b1, 1'b0, 1'b1, 2'd0, 16'hA1B2};
        vecs[10] = '{11'd5, 1'b1, 1'b0, 1'b0, 2'd0, 16'hA1B2};
        vecs[11] = '{11'd5, 1'b1, 1'b1, 1'b0, 2'd0, 16'hA1B2};
        vecs[12] = '{11'd5, 1'b1, 1'b0, 1'b0, 2'd0, 16'hA1B2};
        vecs[13] = '{11'd5, 1'b1, 1'b0, 1'b0, 2'd1, 16'hA1B2};
        vecs[14] = '{11'd5, 1'b1, 1'b0, 1'b0, 2'd1, 16'hA1B2};
        vecs[15] = '{11'd5, 1'b1, 1'b1, 1'b0, 2'd1, 16'hA1B2};
        vecs[16] = '{11'd5, 1'b1, 1'b0, 1'b0, 2'd1, 16'hA1B2};
        vecs[17] = '{11'd5, 1'b1, 1'b0, 1'b1, 2'd0, 16'hC3D4};

        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 18; i++) begin
            usedw     = vecs[i].usedw;
            out_ready = vecs[i].rdy;
            #1;
            check("vec_read",  32'(read_ena),   32'(vecs[i].re));
            check("vec_valid", 32'(out_valid),  32'(vecs[i].ov));
            check("vec_fill",  32'(fill_count), 32'(vecs[i].fill));
            check("vec_data",  32'(out_data),   32'(vecs[i].data));
            tick();
        end

        // Empty FIFO with the counter parked at its terminal value (cycles 19..24)
        usedw = '0;
        for (int c = 19; c <= 24; c++) begin
            #1;
            check("empty_read", 32'(read_ena), 0);
            tick();
        end
        usedw = 11'd1;
        #1;
        check("empty_resume_read", 32'(read_ena), 1);
        tick();
        check("empty_after_read", 32'(read_ena), 0);
        tick();
        check("empty_fill", 32'(fill_count), 1);

        // Backpressure: second byte read at cycle 29, word stalls from cycle 31
        usedw     = 11'd5;
        out_ready = 1'b0;
        tick();
        tick();
        check("bp_read_29", 32'(read_ena), 1);
        tick();
        tick();
        for (int c = 31; c <= 40; c++) begin
            #1;
            check("bp_read",  32'(read_ena), 0);
            check("bp_valid", 32'(out_valid), 1);
            check("bp_data",  32'(out_data), 32'hE5F6);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_read", 32'(read_ena), 1);
        tick();
        check("bp_valid_clear", 32'(out_valid), 0);
        check("bp_no_read", 32'(read_ena), 0);
        tick();
        check("bp_fill", 32'(fill_count), 1);

        // Reset with one byte held: packer empties and pacing restarts from zero
        #1;
        reset = 1'b1;
        tick();
        check("mid_rst_fill",  32'(fill_count), 0);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data",  32'(out_data), 0);
        check("mid_rst_read",  32'(read_ena), 0);
        reset = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check("mid_rst_pace", 32'(read_ena), 32'(c == 4));
            tick();
        end
        tick();
        usedw = '0;
        check("mid_rst_fill_one", 32'(fill_count), 1);
        repeat (6) tick();
        check("sb_empty", 32'(sb.size()), 0);
        check("words_seen", 32'(words_seen), 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
